cheshire_addr_map_rt: RTL and testbench
=======================================

// Module: cheshire_addr_map_rt
// PURPOSE
// Runtime-programmable address decoder for the AXI/reg crossbars; succeeds elaboration-time rule maps.
// Holds NumRules {idx,start,end,en} rules in a shadow table (software-written) and an active table (used).
// Commit copies shadow to active atomically once in-flight lookups drain; lookups are valid/ready pipelined.
// Sits beside a crossbar demux: address in, output port index/hit/multi-hit out.
// PARAMETERS
// NumRules    16   number of rule slots (1..64)
// AddrWidth   48   lookup and rule address width
// IdxWidth    6    width of the port index in each rule
// DefaultIdx  0    index returned on miss (error/debug slave)
// PORTS
// clk_i          in   1            clock
// rst_i          in   1            async reset, active-high
// cfg_valid_i    in   1            shadow rule write request
// cfg_ready_o    out  1            shadow write accepted
// cfg_slot_i     in   $clog2(NumRules) rule slot to write
// cfg_rule_i     in   rt_rule_t    {en, idx, start, end} written to the shadow slot
// commit_i       in   1            request shadow->active copy (level; sampled only in ACTIVE)
// commit_ack_o   out  1            one-cycle pulse on the cycle the active table updates
// lkp_valid_i    in   1            lookup request
// lkp_ready_o    out  1            lookup accepted
// lkp_addr_i     in   AddrWidth    lookup address
// res_valid_o    out  1            result valid
// res_ready_i    in   1            result consumed
// res_idx_o      out  IdxWidth     matched port index, or DefaultIdx on miss
// res_hit_o      out  1            at least one enabled rule matched
// res_multi_o    out  1            more than one enabled rule matched (overlap)
// BEHAVIOUR
// - Reset: both tables cleared (en=0), FSM=ACTIVE, res_valid_o=0, res_idx_o=DefaultIdx,
//   res_hit_o=0, res_multi_o=0, commit_ack_o=0, cfg_ready_o=1.
// - Match: rule matches iff en && start<=addr<end (unsigned, AddrWidth). start>=end never matches.
// - Priority: lowest slot number wins; res_multi_o=1 when two or more rules match.
// - Lookup latency 1: result registered on lkp_valid_i&&lkp_ready_o, using the active table at that edge.
// - lkp_ready_o = (state==ACTIVE) && (!res_valid_o || res_ready_i). Full-throughput back-to-back.
// - Result held stable while res_valid_o && !res_ready_i; res_valid_o drops after handshake with no new lookup.
// - Shadow write completes on cfg_valid_i&&cfg_ready_o. cfg_ready_o=0 only in COPY. Active table unaffected.
// - FSM ACTIVE: commit_i=1 -> PENDING (a lookup accepted in the same cycle still completes).
// - FSM PENDING: lookups stalled; when !res_valid_o or res_valid_o&&res_ready_i -> COPY.
// - FSM COPY: active<=shadow, commit_ack_o=1, -> ACTIVE. The first lookup after COPY uses the new table.
// - A shadow write in the same cycle as entry to COPY lands before the copy (copy takes the write-updated shadow).
// - Reset mid-PENDING/COPY: tables cleared and no ack is issued.
// STRUCTURE
// - cheshire_pkg gains typedef rt_rule_t {logic en; idx; start; end}, sized from AddrWidth/IdxWidth.
// - Sub-module cheshire_addr_match: combinational comparator array plus priority encoder
//   returning {idx, hit, multi}. The top level holds the tables, FSM and output register.
// TESTING
// 1 Reset, lookup 0x1234 -> idx=DefaultIdx, hit=0, multi=0, latency 1 cycle.
// 2 Shadow slot0 {1,3,0x1000,0x2000}, commit -> ack pulse. Lookup 0x1FFF -> idx 3, hit;
//   0x2000 -> miss.
// 3 Slot1 {1,5,0x1800,0x3000} overlaps slot0. Lookup 0x1900 -> idx 3, multi=1;
//   0x2800 -> idx 5, multi=0.
// 4 Hold res_ready_i=0 for 4 cycles with a result pending and raise commit_i -> lkp_ready_o=0,
//   no ack until the result drains. The next lookup uses the new table.
// 5 Shadow write without commit -> lookups still use the old table. Rule start=end=0x40 -> never hits.
// 6 Streaming lookups with res_ready_i=1 -> one result per cycle, order preserved.
//   Assert rst_i mid-stream -> res_valid_o=0 and all lookups miss.

Source files
------------

// File: rtl/cheshire_pkg.sv
// rtl/cheshire_pkg.sv - shared types for the runtime-programmable address map
package cheshire_pkg;

    localparam int unsigned RtAddrWidth = 48;
    localparam int unsigned RtIdxWidth  = 6;

    typedef struct packed {
        logic                   en;
        logic [RtIdxWidth-1:0]  idx;
        logic [RtAddrWidth-1:0] start_addr;
        logic [RtAddrWidth-1:0] end_addr;
    } rt_rule_t;

    typedef enum logic [1:0] {
        RT_ACTIVE  = 2'd0,
        RT_PENDING = 2'd1,
        RT_COPY    = 2'd2
    } rt_state_e;

    // Half-open range; an empty or inverted range (start >= end) never matches.
    function automatic logic rt_rule_match(input rt_rule_t rule, input logic [RtAddrWidth-1:0] addr);
        return rule.en && (rule.start_addr <= addr) && (addr < rule.end_addr);
    endfunction

endpackage

// File: rtl/cheshire_addr_match.sv
// rtl/cheshire_addr_match.sv - comparator array and lowest-slot-wins priority encoder
module cheshire_addr_match
    import cheshire_pkg::*;
#(
    parameter int unsigned          NumRules   = 16,
    parameter int unsigned          AddrWidth  = RtAddrWidth,
    parameter int unsigned          IdxWidth   = RtIdxWidth,
    parameter logic [IdxWidth-1:0]  DefaultIdx = '0
) (
    input  rt_rule_t               rules_i [NumRules],
    input  logic [AddrWidth-1:0]   addr_i,
    output logic [IdxWidth-1:0]    idx_o,
    output logic                   hit_o,
    output logic                   multi_o
);

    always_comb begin
        idx_o   = DefaultIdx;
        hit_o   = 1'b0;
        multi_o = 1'b0;
        for (int i = 0; i < NumRules; i++) begin
            if (rt_rule_match(rules_i[i], addr_i)) begin
                if (hit_o) begin
                    multi_o = 1'b1;
                end else begin
                    idx_o = rules_i[i].idx;
                end
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cheshire_addr_map_rt.sv
// rtl/cheshire_addr_map_rt.sv - shadow/active rule tables with drained atomic commit
module cheshire_addr_map_rt
    import cheshire_pkg::*;
#(
    parameter int unsigned          NumRules   = 16,
    parameter int unsigned          AddrWidth  = RtAddrWidth,
    parameter int unsigned          IdxWidth   = RtIdxWidth,
    parameter logic [IdxWidth-1:0]  DefaultIdx = '0,
    localparam int unsigned         SlotW      = (NumRules > 1) ? $clog2(NumRules) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [SlotW-1:0]       cfg_slot_i,
    input  rt_rule_t               cfg_rule_i,
    input  logic                   commit_i,
    output logic                   commit_ack_o,
    input  logic                   lkp_valid_i,
    output logic                   lkp_ready_o,
    input  logic [AddrWidth-1:0]   lkp_addr_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [IdxWidth-1:0]    res_idx_o,
    output logic                   res_hit_o,
    output logic                   res_multi_o
);

    rt_state_e             state_q;
    rt_rule_t              shadow_q [NumRules];
    rt_rule_t              active_q [NumRules];
    logic                  res_valid_q, res_hit_q, res_multi_q, ack_q;
    logic [IdxWidth-1:0]   res_idx_q;
    logic [IdxWidth-1:0]   m_idx;
    logic                  m_hit, m_multi;

    cheshire_addr_match #(
        .NumRules   (NumRules),
        .AddrWidth  (AddrWidth),
        .IdxWidth   (IdxWidth),
        .DefaultIdx (DefaultIdx)
    ) u_match (
        .rules_i (active_q),
        .addr_i  (lkp_addr_i),
        .idx_o   (m_idx),
        .hit_o   (m_hit),
        .multi_o (m_multi)
    );

    assign lkp_ready_o  = (state_q == RT_ACTIVE) && (!res_valid_q || res_ready_i);
    assign cfg_ready_o  = (state_q != RT_COPY);
    assign commit_ack_o = ack_q;
    assign res_valid_o  = res_valid_q;
    assign res_idx_o    = res_idx_q;
    assign res_hit_o    = res_hit_q;
    assign res_multi_o  = res_multi_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RT_ACTIVE;
            shadow_q    <= '{default: '0};
            active_q    <= '{default: '0};
            res_valid_q <= 1'b0;
            res_idx_q   <= DefaultIdx;
            res_hit_q   <= 1'b0;
            res_multi_q <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (cfg_valid_i && cfg_ready_o && (int'(cfg_slot_i) < NumRules)) begin
                shadow_q[cfg_slot_i] <= cfg_rule_i;
            end
            if (lkp_valid_i && lkp_ready_o) begin
                res_valid_q <= 1'b1;
                res_idx_q   <= m_idx;
                res_hit_q   <= m_hit;
                res_multi_q <= m_multi;
            end else if (res_ready_i) begin
                res_valid_q <= 1'b0;
            end
            // COPY only starts once the output register holds nothing from the old table.
            case (state_q)
                RT_ACTIVE:  if (commit_i) state_q <= RT_PENDING;
                RT_PENDING: if (!res_valid_q || res_ready_i) state_q <= RT_COPY;
                RT_COPY: begin
                    active_q <= shadow_q;
                    ack_q    <= 1'b1;
                    state_q  <= RT_ACTIVE;
                end
                default:    state_q <= RT_ACTIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_cheshire_addr_map_rt.sv
// tb/tb_cheshire_addr_map_rt.sv - directed self-checking bench for cheshire_addr_map_rt
module tb_cheshire_addr_map_rt;
    import cheshire_pkg::*;

    localparam logic [5:0] DEF = 6'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [3:0]  cfg_slot = '0;
    rt_rule_t    cfg_rule = '0;
    logic        commit = 1'b0;
    logic        commit_ack;
    logic        lkp_valid = 1'b0;
    logic        lkp_ready;
    logic [47:0] lkp_addr = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [5:0]  res_idx;
    logic        res_hit;
    logic        res_multi;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    cheshire_addr_map_rt #(.DefaultIdx(DEF)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_slot_i   (cfg_slot),
        .cfg_rule_i   (cfg_rule),
        .commit_i     (commit),
        .commit_ack_o (commit_ack),
        .lkp_valid_i  (lkp_valid),
        .lkp_ready_o  (lkp_ready),
        .lkp_addr_i   (lkp_addr),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_idx_o    (res_idx),
        .res_hit_o    (res_hit),
        .res_multi_o  (res_multi)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observed result packed as {valid, hit, multi, idx}.
    task automatic lookup(input logic [47:0] a, output logic [8:0] obs);
        lkp_valid = 1'b1;
        lkp_addr  = a;
        res_ready = 1'b1;
        tick();
        lkp_valid = 1'b0;
        obs = {res_valid, res_hit, res_multi, res_idx};
    endtask

    task automatic write_rule(input logic [3:0] slot, input logic [5:0] idx,
                              input logic [47:0] s, input logic [47:0] e);
        cfg_valid = 1'b1;
        cfg_slot  = slot;
        cfg_rule  = '{en: 1'b1, idx: idx, start_addr: s, end_addr: e};
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_commit(output int lat, output int acks);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        lat = -1;
        acks = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (commit_ack) begin
                acks++;
                if (lat < 0) lat = i;
            end
        end
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        tests_run++;
        if ({res_valid, res_hit, res_multi, res_idx, commit_ack, cfg_ready, lkp_ready} !== {3'b000, DEF, 3'b011}) begin
            tests_failed++;
            $display("FAIL reset_state got=%b exp=%b",
                     {res_valid, res_hit, res_multi, res_idx, commit_ack, cfg_ready, lkp_ready}, {3'b000, DEF, 3'b011});
        end
        lookup(48'h1234, obs);
        tests_run++;
        if (obs !== {3'b100, DEF}) begin
            tests_failed++;
            $display("FAIL reset_lookup got=%h exp=%h", obs, {3'b100, DEF});
        end
        tick();
        tests_run++;
        if (res_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_drain got=%b exp=0", res_valid);
        end
    endtask

    task automatic test_single_rule();
        logic [8:0] obs;
        int lat, acks;
        tests_run++;
        if (cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL cfg_ready got=%b exp=1", cfg_ready);
        end
        write_rule(4'd0, 6'd3, 48'h1000, 48'h2000);
        do_commit(lat, acks);
        tests_run++;
        if (lat !== 2 || acks !== 1) begin
            tests_failed++;
            $display("FAIL commit_ack got lat=%0d acks=%0d exp lat=2 acks=1", lat, acks);
        end
        lookup(48'h1FFF, obs);
        tests_run++;
        if (obs !== {3'b110, 6'd3}) begin
            tests_failed++;
            $display("FAIL hit_top got=%h exp=%h", obs, {3'b110, 6'd3});
        end
        lookup(48'h1000, obs);
        tests_run++;
        if (obs !== {3'b110, 6'd3}) begin
            tests_failed++;
            $display("FAIL hit_start got=%h exp=%h", obs, {3'b110, 6'd3});
        end
        lookup(48'h2000, obs);
        tests_run++;
        if (obs !== {3'b100, DEF}) begin
            tests_failed++;
            $display("FAIL miss_end got=%h exp=%h", obs, {3'b100, DEF});
        end
    endtask

    task automatic test_overlap();
        logic [8:0] obs;
        int lat, acks;
        write_rule(4'd1, 6'd5, 48'h1800, 48'h3000);
        do_commit(lat, acks);
        lookup(48'h1900, obs);
        tests_run++;
        if (obs !== {3'b111, 6'd3}) begin
            tests_failed++;
            $display("FAIL overlap_multi got=%h exp=%h", obs, {3'b111, 6'd3});
        end
        lookup(48'h2800, obs);
        tests_run++;
        if (obs !== {3'b110, 6'd5}) begin
            tests_failed++;
            $display("FAIL overlap_single got=%h exp=%h", obs, {3'b110, 6'd5});
        end
    endtask

    task automatic test_commit_stall();
        logic [8:0] obs;
        write_rule(4'd0, 6'd9, 48'h1000, 48'h2000);
        lkp_valid = 1'b1;
        lkp_addr  = 48'h1900;
        res_ready = 1'b0;
        tick();
        lkp_valid = 1'b0;
        commit    = 1'b1;
        tick();
        commit    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({lkp_ready, commit_ack, res_valid, res_idx} !== {3'b001, 6'd3}) begin
                tests_failed++;
                $display("FAIL stall_cycle%0d got=%b exp=%b", i, {lkp_ready, commit_ack, res_valid, res_idx}, {3'b001, 6'd3});
            end
            tick();
        end
        res_ready = 1'b1;
        cfg_valid = 1'b1;
        cfg_slot  = 4'd4;
        cfg_rule  = '{en: 1'b1, idx: 6'd13, start_addr: 48'h8000, end_addr: 48'h9000};
        tick();
        cfg_valid = 1'b0;
        tests_run++;
        if ({commit_ack, res_valid, cfg_ready, lkp_ready} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL copy_cycle got=%b exp=0000", {commit_ack, res_valid, cfg_ready, lkp_ready});
        end
        tick();
        tests_run++;
        if ({commit_ack, lkp_ready} !== 2'b11) begin
            tests_failed++;
            $display("FAIL ack_after_drain got=%b exp=11", {commit_ack, lkp_ready});
        end
        lookup(48'h1900, obs);
        tests_run++;
        if (obs !== {3'b111, 6'd9}) begin
            tests_failed++;
            $display("FAIL new_table got=%h exp=%h", obs, {3'b111, 6'd9});
        end
        lookup(48'h8800, obs);
        tests_run++;
        if (obs !== {3'b110, 6'd13}) begin
            tests_failed++;
            $display("FAIL write_before_copy got=%h exp=%h", obs, {3'b110, 6'd13});
        end
    endtask

    task automatic test_shadow_only();
        logic [8:0] obs;
        int lat, acks;
        write_rule(4'd2, 6'd11, 48'h5000, 48'h6000);
        lookup(48'h5800, obs);
        tests_run++;
        if (obs !== {3'b100, DEF}) begin
            tests_failed++;
            $display("FAIL shadow_isolated got=%h exp=%h", obs, {3'b100, DEF});
        end
        write_rule(4'd3, 6'd12, 48'h40, 48'h40);
        do_commit(lat, acks);
        lookup(48'h5800, obs);
        tests_run++;
        if (obs !== {3'b110, 6'd11}) begin
            tests_failed++;
            $display("FAIL shadow_committed got=%h exp=%h", obs, {3'b110, 6'd11});
        end
        lookup(48'h40, obs);
        tests_run++;
        if (obs !== {3'b100, DEF}) begin
            tests_failed++;
            $display("FAIL empty_range got=%h exp=%h", obs, {3'b100, DEF});
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] addrs [5] = '{48'h1100, 48'h2800, 48'h5100, 48'h7000, 48'h8000};
        logic [8:0]  exps  [5] = '{{3'b110, 6'd9}, {3'b110, 6'd5}, {3'b110, 6'd11}, {3'b100, DEF}, {3'b110, 6'd13}};
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            lkp_valid = 1'b1;
            lkp_addr  = addrs[i];
            tests_run++;
            if (lkp_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL stream_ready%0d got=%b exp=1", i, lkp_ready);
            end
            tick();
            tests_run++;
            if ({res_valid, res_hit, res_multi, res_idx} !== exps[i]) begin
                tests_failed++;
                $display("FAIL stream%0d got=%h exp=%h", i, {res_valid, res_hit, res_multi, res_idx}, exps[i]);
            end
        end
        lkp_addr = 48'h1100;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({res_valid, commit_ack} !== 2'b00) begin
            tests_failed++;
            $display("FAIL midstream_reset got=%b exp=00", {res_valid, commit_ack});
        end
        tick();
        rst = 1'b0;
        tick();
        lkp_valid = 1'b0;
        tests_run++;
        if ({res_valid, res_hit, res_multi, res_idx} !== {3'b100, DEF}) begin
            tests_failed++;
            $display("FAIL post_reset_miss got=%h exp=%h", {res_valid, res_hit, res_multi, res_idx}, {3'b100, DEF});
        end
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_single_rule();
        test_overlap();
        test_commit_stall();
        test_shadow_only();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
